// File: rtl/sensor_seq_ctrl_if.sv
// rtl/sensor_seq_ctrl_if.sv - control and timing signal bundle of the linear-sensor sequencer
interface sensor_seq_ctrl_if #(
    parameter int CH_W  = 8,
    parameter int CYC_W = 32
);
    logic             enable;
    logic             mode;
    logic             start;
    logic [15:0]      integ_ext;
    logic             sen_rst;
    logic             acq_timing;
    logic [CH_W-1:0]  ch_index;
    logic             frame_start;
    logic             frame_done;
    logic             busy;
    logic [CYC_W-1:0] cycle_count;

    modport master (
        output enable, mode, start, integ_ext,
        input  sen_rst, acq_timing, ch_index, frame_start, frame_done, busy, cycle_count
    );

    modport slave (
        input  enable, mode, start, integ_ext,
        output sen_rst, acq_timing, ch_index, frame_start, frame_done, busy, cycle_count
    );
endinterface

// File: rtl/sensor_seq_ctrl.sv
// rtl/sensor_seq_ctrl.sv - linear-sensor sequencer: reset pulse, quiet time, per-channel sample strobes
module sensor_seq_ctrl #(
    parameter int CHANNELS     = 256,
    parameter int CLKS_PER_CH  = 4,
    parameter int RST_PW       = 21,
    parameter int QUIET_TIME   = 18,
    parameter int SAMPLE_PHASE = 3,
    parameter int CYC_W        = 32,
    parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk_4M,
    input  logic              sys_rst_n,
    sensor_seq_ctrl_if.slave  bus
);
    localparam int N       = CHANNELS * CLKS_PER_CH;
    localparam int M1      = (RST_PW > QUIET_TIME) ? RST_PW : QUIET_TIME;
    localparam int M2      = (M1 > N) ? M1 : N;
    localparam int CNT_MAX = (M2 > 65535) ? M2 : 65535;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int PH_W    = (CLKS_PER_CH > 1) ? $clog2(CLKS_PER_CH) : 1;
    localparam int CH_W_EXP = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    if (CHANNELS < 1 || CLKS_PER_CH < 1 || RST_PW < 1 || QUIET_TIME < 1 || CYC_W < 1) begin : g_bad_width
        $error("sensor_seq_ctrl: zero or negative width parameter");
    end
    if (SAMPLE_PHASE < 0 || SAMPLE_PHASE >= CLKS_PER_CH) begin : g_bad_phase
        $error("sensor_seq_ctrl: SAMPLE_PHASE outside the channel slot");
    end
    if (CH_W != CH_W_EXP) begin : g_bad_chw
        $error("sensor_seq_ctrl: CH_W does not match CHANNELS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTP,
        S_QUIET,
        S_READ,
        S_INTEG
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [15:0]       integ_q, integ_d;
    logic              frame_end;

    logic              sen_rst_q, sen_rst_d;
    logic              acq_q, acq_d;
    logic [CH_W-1:0]   ch_index_q, ch_index_d;
    logic              fs_q, fs_d;
    logic              fd_q, fd_d;
    logic              busy_q, busy_d;
    logic [CYC_W-1:0]  cc_q, cc_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        phase_d   = '0;
        ch_d      = '0;
        integ_d   = integ_q;
        frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.enable && (!bus.mode || bus.start)) begin
                    state_d = S_RSTP;
                end
            end
            S_RSTP: begin
                // integration extension is frozen for the whole frame at cycle 0
                if (cnt_q == '0) begin
                    integ_d = bus.integ_ext;
                end
                if (cnt_q == CNT_W'(RST_PW - 1)) begin
                    state_d = S_QUIET;
                    cnt_d   = '0;
                end
            end
            S_QUIET: begin
                if (cnt_q == CNT_W'(QUIET_TIME - 1)) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                phase_d = phase_q + PH_W'(1);
                ch_d    = ch_q;
                if (phase_q == PH_W'(CLKS_PER_CH - 1)) begin
                    phase_d = '0;
                    ch_d    = ch_q + CH_W'(1);
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    if (integ_q != '0) begin
                        state_d = S_INTEG;
                        cnt_d   = '0;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            S_INTEG: begin
                if (cnt_q == CNT_W'(integ_q) - CNT_W'(1)) begin
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // enable/mode are only consulted here, so a running frame is never cut short
        if (frame_end) begin
            cnt_d   = '0;
            state_d = (!bus.mode && bus.enable) ? S_RSTP : S_IDLE;
        end

        busy_d     = (state_d != S_IDLE);
        sen_rst_d  = (state_d == S_IDLE) || (state_d == S_RSTP);
        fs_d       = (state_d == S_QUIET) && (cnt_d == '0);
        fd_d       = (state_d == S_READ) && (cnt_d == CNT_W'(N - 1));
        acq_d      = (state_d == S_READ) && (phase_d == PH_W'(SAMPLE_PHASE));
        ch_index_d = acq_d ? ch_d : ch_index_q;
        cc_d       = fs_d ? cc_q + CYC_W'(1) : cc_q;
    end

    always_ff @(posedge clk_4M) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phase_q    <= '0;
            ch_q       <= '0;
            integ_q    <= '0;
            sen_rst_q  <= 1'b1;
            acq_q      <= 1'b0;
            ch_index_q <= '0;
            fs_q       <= 1'b0;
            fd_q       <= 1'b0;
            busy_q     <= 1'b0;
            cc_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            ch_q       <= ch_d;
            integ_q    <= integ_d;
            sen_rst_q  <= sen_rst_d;
            acq_q      <= acq_d;
            ch_index_q <= ch_index_d;
            fs_q       <= fs_d;
            fd_q       <= fd_d;
            busy_q     <= busy_d;
            cc_q       <= cc_d;
        end
    end

    assign bus.sen_rst     = sen_rst_q;
    assign bus.acq_timing  = acq_q;
    assign bus.ch_index    = ch_index_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_done  = fd_q;
    assign bus.busy        = busy_q;
    assign bus.cycle_count = cc_q;
endmodule

// File: tb/tb_sensor_seq_ctrl.sv
// tb/tb_sensor_seq_ctrl.sv - bench for sensor_seq_ctrl (default instance and a small instance)
module tb_sensor_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, mode, start;
    logic [15:0] integ;

    always #5 clk = ~clk;

    sensor_seq_ctrl_if #(.CH_W(8), .CYC_W(32)) bus_a ();
    sensor_seq_ctrl_if #(.CH_W(3), .CYC_W(4))  bus_b ();

    assign bus_a.enable = enable;  assign bus_b.enable = enable;
    assign bus_a.mode = mode;      assign bus_b.mode = mode;
    assign bus_a.start = start;    assign bus_b.start = start;
    assign bus_a.integ_ext = integ; assign bus_b.integ_ext = integ;

    sensor_seq_ctrl u_a (.clk_4M(clk), .sys_rst_n(rst_n), .bus(bus_a));
    sensor_seq_ctrl #(.CHANNELS(8), .CLKS_PER_CH(2), .RST_PW(3), .QUIET_TIME(2),
                      .SAMPLE_PHASE(0), .CYC_W(4)) u_b (.clk_4M(clk), .sys_rst_n(rst_n), .bus(bus_b));

    localparam int     P_CH  [2] = '{256, 8};
    localparam int     P_CPC [2] = '{4, 2};
    localparam int     P_RST [2] = '{21, 3};
    localparam int     P_QT  [2] = '{18, 2};
    localparam int     P_SP  [2] = '{3, 0};
    localparam longint P_MASK[2] = '{64'hFFFF_FFFF, 64'hF};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // frame-position reference model: position t within the current frame
    bit     m_act[2];
    int     m_t[2], m_integ[2], m_ch[2];
    longint m_cc[2];
    bit     e_sen[2], e_acq[2], e_fs[2], e_fd[2], e_busy[2];

    int a_fs[$], a_st[$], a_ch[$], a_fd[$], a_idle[$];
    longint a_fscc[$];
    int b_fs[$], b_st[$], b_ch[$], b_fd[$], b_idle[$];
    bit pb_a, pb_b;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int i);
        int r, n, rel;
        r = P_RST[i] + P_QT[i];
        n = P_CH[i] * P_CPC[i];
        if (!rst_n) begin
            m_act[i] = 0; m_t[i] = 0; m_cc[i] = 0; m_ch[i] = 0; m_integ[i] = 0;
        end else if (!m_act[i]) begin
            if (enable && (!mode || start)) begin
                m_act[i] = 1; m_t[i] = 0;
            end
        end else begin
            if (m_t[i] == 0) m_integ[i] = int'(integ);
            m_t[i]++;
            if (m_t[i] == r + n + m_integ[i]) begin
                if (!mode && enable) m_t[i] = 0;
                else m_act[i] = 0;
            end
        end
        rel = m_t[i] - r;
        e_busy[i] = m_act[i];
        e_sen[i]  = !m_act[i] || (m_t[i] < P_RST[i]);
        e_fs[i]   = m_act[i] && (m_t[i] == P_RST[i]);
        e_fd[i]   = m_act[i] && (m_t[i] == r + n - 1);
        e_acq[i]  = m_act[i] && rel >= 0 && rel < n && (rel % P_CPC[i]) == P_SP[i];
        if (e_fs[i]) m_cc[i] = (m_cc[i] + 1) & P_MASK[i];
        if (e_acq[i]) m_ch[i] = rel / P_CPC[i];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cyc++;
        chk("a_sen_rst", bus_a.sen_rst, e_sen[0]);
        chk("a_acq", bus_a.acq_timing, e_acq[0]);
        chk("a_ch_index", bus_a.ch_index, m_ch[0]);
        chk("a_frame_start", bus_a.frame_start, e_fs[0]);
        chk("a_frame_done", bus_a.frame_done, e_fd[0]);
        chk("a_busy", bus_a.busy, e_busy[0]);
        chk("a_cycle_count", bus_a.cycle_count, m_cc[0]);
        chk("b_sen_rst", bus_b.sen_rst, e_sen[1]);
        chk("b_acq", bus_b.acq_timing, e_acq[1]);
        chk("b_ch_index", bus_b.ch_index, m_ch[1]);
        chk("b_frame_start", bus_b.frame_start, e_fs[1]);
        chk("b_frame_done", bus_b.frame_done, e_fd[1]);
        chk("b_busy", bus_b.busy, e_busy[1]);
        chk("b_cycle_count", bus_b.cycle_count, m_cc[1]);
        if (bus_a.frame_start) begin a_fs.push_back(cyc); a_fscc.push_back(longint'(bus_a.cycle_count)); end
        if (bus_a.acq_timing) begin a_st.push_back(cyc); a_ch.push_back(int'(bus_a.ch_index)); end
        if (bus_a.frame_done) a_fd.push_back(cyc);
        if (pb_a && !bus_a.busy) a_idle.push_back(cyc);
        if (bus_b.frame_start) b_fs.push_back(cyc);
        if (bus_b.acq_timing) begin b_st.push_back(cyc); b_ch.push_back(int'(bus_b.ch_index)); end
        if (bus_b.frame_done) b_fd.push_back(cyc);
        if (pb_b && !bus_b.busy) b_idle.push_back(cyc);
        pb_a = bus_a.busy;
        pb_b = bus_b.busy;
    endtask

    task automatic clear_logs();
        a_fs.delete(); a_fscc.delete(); a_st.delete(); a_ch.delete(); a_fd.delete(); a_idle.delete();
        b_fs.delete(); b_st.delete(); b_ch.delete(); b_fd.delete(); b_idle.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; mode = 1'b0; integ = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic wait_busy(input int i, output int c0);
        bit got;
        got = 0;
        c0 = -1;
        for (int k = 0; k < 50 && !got; k++) begin
            tick();
            if ((i == 0 && bus_a.busy) || (i == 1 && bus_b.busy)) begin
                got = 1;
                c0 = cyc;
            end
        end
        if (!got) chk("wait_busy_timeout", 0, 1);
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -100000;
    endfunction

    typedef struct {
        bit mode;
        int integ;
        int first_stb;
        int last_stb;
        int n_stb;
        int done;
        int len;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int c0, c1, bad, cnt, nst;

        tbl[0] = '{mode: 1, integ: 0, first_stb: 5, last_stb: 19, n_stb: 8, done: 20, len: 21};
        tbl[1] = '{mode: 1, integ: 3, first_stb: 5, last_stb: 19, n_stb: 8, done: 20, len: 24};
        tbl[2] = '{mode: 0, integ: 0, first_stb: 5, last_stb: 19, n_stb: 8, done: 20, len: 21};
        tbl[3] = '{mode: 0, integ: 2, first_stb: 5, last_stb: 19, n_stb: 8, done: 20, len: 23};

        pb_a = 0; pb_b = 0;
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; start = 1'b0; integ = '0;
        repeat (3) tick();
        chk("rst_sen_rst", bus_a.sen_rst, 1);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_cycle_count", bus_a.cycle_count, 0);
        chk("rst_ch_index", bus_b.ch_index, 0);
        chk("rst_acq", bus_b.acq_timing, 0);

        // small-instance frame geometry
        foreach (tbl[v]) begin
            do_reset();
            mode = tbl[v].mode; integ = 16'(tbl[v].integ); enable = 1'b1; start = tbl[v].mode;
            wait_busy(1, c0);
            start = 1'b0;
            repeat (60) tick();
            enable = 1'b0;
            repeat (40) tick();
            chk($sformatf("tbl%0d_first_stb", v), qat(b_st, 0) - c0, tbl[v].first_stb);
            chk($sformatf("tbl%0d_last_stb", v), qat(b_st, tbl[v].n_stb - 1) - c0, tbl[v].last_stb);
            cnt = 0;
            foreach (b_st[k]) if (b_st[k] < c0 + tbl[v].len) cnt++;
            chk($sformatf("tbl%0d_n_stb", v), cnt, tbl[v].n_stb);
            chk($sformatf("tbl%0d_done", v), qat(b_fd, 0) - c0, tbl[v].done);
            chk($sformatf("tbl%0d_fs", v), qat(b_fs, 0) - c0, 3);
            if (tbl[v].mode) chk($sformatf("tbl%0d_len", v), qat(b_idle, 0) - c0, tbl[v].len);
            else chk($sformatf("tbl%0d_len", v), qat(b_fs, 1) - qat(b_fs, 0), tbl[v].len);
            bad = 0;
            for (int k = 0; k < 8; k++) if (qat(b_ch, k) != k) bad++;
            chk($sformatf("tbl%0d_ch_seq", v), bad, 0);
        end

        // default instance, continuous
        do_reset();
        enable = 1'b1;
        wait_busy(0, c0);
        repeat (3 * 1063 + 9) tick();
        chk("cont_fs0", qat(a_fs, 0) - c0, 21);
        chk("cont_period1", qat(a_fs, 1) - qat(a_fs, 0), 1063);
        chk("cont_period2", qat(a_fs, 2) - qat(a_fs, 1), 1063);
        chk("cont_cc1", a_fscc.size() > 0 ? a_fscc[0] : -1, 1);
        chk("cont_cc2", a_fscc.size() > 1 ? a_fscc[1] : -1, 2);
        chk("cont_cc3", a_fscc.size() > 2 ? a_fscc[2] : -1, 3);
        chk("cont_first_stb", qat(a_st, 0) - c0, 42);
        chk("cont_stb_spacing", qat(a_st, 1) - qat(a_st, 0), 4);
        chk("cont_last_stb", qat(a_st, 255) - c0, 1062);
        chk("cont_next_frame_stb", qat(a_st, 256) - c0, 1063 + 42);
        chk("cont_done", qat(a_fd, 0) - c0, 1062);
        bad = 0;
        for (int k = 0; k < 256; k++) if (qat(a_ch, k) != k) bad++;
        chk("cont_ch_seq", bad, 0);

        // integ_ext changed 10 cycles into a frame only stretches the following frame
        integ = 16'd100;
        clear_logs();
        repeat (2400) tick();
        chk("integ_cur_frame", qat(a_fs, 1) - qat(a_fs, 0), 1063);
        chk("integ_next_frame", qat(a_fs, 2) - qat(a_fs, 1), 1163);

        // enable dropped mid-frame
        do_reset();
        enable = 1'b1;
        wait_busy(0, c0);
        repeat (300) tick();
        enable = 1'b0;
        repeat (900) tick();
        chk("endrop_strobes", a_st.size(), 256);
        chk("endrop_idle", qat(a_idle, 0) - c0, 1063);
        chk("endrop_frames", a_fs.size(), 1);

        // single shot with an ignored second start
        do_reset();
        mode = 1'b1; enable = 1'b1; start = 1'b1;
        wait_busy(0, c0);
        start = 1'b0;
        repeat (500) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (700) tick();
        chk("single_done", qat(a_fd, 0) - c0, 1062);
        chk("single_n_done", a_fd.size(), 1);
        chk("single_idle", qat(a_idle, 0) - c0, 1063);
        chk("single_strobes", a_st.size(), 256);
        chk("single_frames", a_fs.size(), 1);

        // reset mid-frame
        do_reset();
        enable = 1'b1;
        wait_busy(0, c0);
        repeat (600) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_sen_rst", bus_a.sen_rst, 1);
        chk("midrst_busy", bus_a.busy, 0);
        chk("midrst_cc", bus_a.cycle_count, 0);
        chk("midrst_ch", bus_a.ch_index, 0);
        nst = a_st.size();
        repeat (5) tick();
        chk("midrst_no_strobes", a_st.size(), nst);
        rst_n = 1'b1;
        wait_busy(0, c1);
        repeat (30) tick();
        chk("midrst_restart_fs", a_fs.size() > 0 ? a_fs[a_fs.size() - 1] - c1 : -1, 21);
        chk("midrst_restart_cc", a_fscc.size() > 0 ? a_fscc[a_fscc.size() - 1] : -1, 1);

        // randomized run against the model
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 15000; k++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) integ = 16'($urandom_range(0, 5));
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sensor_seq_ctrl.md
# sensor_seq_ctrl

Parametrised linear-sensor sequencer: generates the sensor reset pulse, waits out the post-reset quiet time, and emits one sample strobe plus channel index per channel during readout. It supports continuous and single-shot frame modes and a run-time integration extension between frames. It sits in the 4 MHz sensor clock domain and feeds the acquisition/ADC capture logic and the frame bookkeeping.

## Interface
- CHANNELS, 256: channels per frame (≥1)
- CLKS_PER_CH, 4: clocks per channel slot (≥1)
- RST_PW, 21: sen_rst high width in clocks (≥1)
- QUIET_TIME, 18: clocks from sen_rst fall to first channel slot (≥1)
- SAMPLE_PHASE, 3: clock within a slot at which acq_timing fires (0..CLKS_PER_CH-1)
- CYC_W, 32: cycle_count width
- CH_W, $clog2(CHANNELS) (min 1): ch_index width, derived
- clk_4M  in  1  sensor clock; all logic on rising edge
- sys_rst_n  in  1  synchronous, active-low reset
- enable  in  1  run permission; continuous mode runs while high
- mode  in  1  0 = continuous, 1 = single-shot
- start  in  1  single-shot trigger; honoured only in IDLE with enable=1, mode=1
- integ_ext  in  16  extra clocks appended after readout; latched at cycle 0 of each frame
- sen_rst  out  1  sensor reset; 1 = sensor held in reset
- acq_timing  out  1  one-clock sample strobe per channel
- ch_index  out  CH_W  channel number, valid when acq_timing=1
- frame_start  out  1  one-clock pulse on the clock sen_rst falls
- frame_done  out  1  one-clock pulse on the last readout clock
- busy  out  1  high from cycle 0 through the last frame clock
- cycle_count  out  CYC_W  completed reset pulses (sen_rst falls), wraps modulo 2^CYC_W

## Operation
- States: IDLE, RSTP, QUIET, READ, INTEG. Single down/up counter per state, wide enough for max(RST_PW, QUIET_TIME, CHANNELS*CLKS_PER_CH, 65535).
- IDLE: sen_rst=1, busy=0. Go to RSTP when (mode=0 and enable=1) or (mode=1 and enable=1 and start=1).
- RSTP: RST_PW clocks, sen_rst=1, then QUIET.
- QUIET: QUIET_TIME clocks, sen_rst=0; first QUIET clock asserts frame_start and increments cycle_count.
- READ: CHANNELS*CLKS_PER_CH clocks; slot k (0..CHANNELS-1) fires acq_timing with ch_index=k at its SAMPLE_PHASE clock; frame_done on the final READ clock.
- INTEG: latched integ_ext clocks, sen_rst=0; skipped when 0.
- At frame end: go to RSTP if mode=0 and enable=1 (sampled on that clock), else IDLE.
- enable low or mode change mid-frame never truncates a frame; it only takes effect at frame end.
- start while busy, or with mode=0, is ignored (not queued).
- ch_index holds its last value between strobes; it is 0 after reset.
- Parameter violations (SAMPLE_PHASE ≥ CLKS_PER_CH, zero widths) are elaboration errors.

## Timing
- All outputs are registered. Reset values: sen_rst=1, acq_timing=0, ch_index=0, frame_start=0, frame_done=0, busy=0, cycle_count=0, state IDLE.
- sys_rst_n=0 at any point, including mid-frame, forces reset values at the next edge and has priority over everything else.
- Cycle 0 is the first clock whose outputs show busy=1, i.e. the clock after the edge that sampled the start condition in IDLE.
- Let R = RST_PW + QUIET_TIME and N = CHANNELS*CLKS_PER_CH.
- sen_rst=1 on cycles 0..RST_PW-1 and 0 from cycle RST_PW; frame_start and the cycle_count increment are visible at cycle RST_PW.
- acq_timing at cycles R + k*CLKS_PER_CH + SAMPLE_PHASE.
- frame_done at cycle R+N-1.
- Frame length L = R + N + integ_ext. Continuous: next cycle 0 at cycle L with no gap, sen_rst rising there. Otherwise busy=0 and sen_rst=1 at cycle L.
- Defaults: first strobe at cycle 42, last at 1062, L=1063 + integ_ext.

## Test plan
- Defaults, mode=0, enable=1, integ_ext=0 -> 256 strobes spaced 4 starting at cycle 42, ch_index 0..255, sen_rst period 1063, cycle_count 1,2,3 at successive sen_rst falls.
- mode=1, single start pulse -> exactly one frame, frame_done at cycle 1062, busy low and sen_rst=1 from cycle 1063; a second start at cycle 500 has no effect.
- integ_ext=100 in continuous mode -> period 1163; changing integ_ext mid-frame affects only the next frame.
- enable dropped at cycle 300 of a continuous frame -> all 256 strobes still issued, then IDLE at 1063.
- sys_rst_n low at cycle 600 -> next edge shows all reset values, no further strobes; after release with enable=1, a new frame starts with cycle_count=1 at cycle RST_PW.
- Instance CHANNELS=8, CLKS_PER_CH=2, SAMPLE_PHASE=0, RST_PW=3, QUIET_TIME=2 -> strobes at cycles 5,7,...,19, frame_done at cycle 20, L=21, CH_W=3.
